usbh_report_decoder_gamepad: RTL and testbench

Parametrised HID-report-to-NES-button decoder. It sits between the USB host core's report output and the NES controller shift-register model, in the USB clock domain. It maps configurable report bit positions and signed analog axes to the 8-bit NES button vector. It adds three behaviours:
- axis hysteresis;
- exact-rate autofire whose phase restarts on press;
- a report-loss watchdog that releases all buttons when the pad stops reporting.

---
 rtl/usbh_report_pkg.sv | 27 ++
 rtl/usbh_axis_hyst.sv | 42 ++++
 rtl/usbh_report_decoder_gamepad.sv | 172 +++++++++++++++++
 tb/tb_usbh_report_decoder_gamepad.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/usbh_report_pkg.sv
// Shared constants for the HID gamepad decoder: NES button order, the button
// vector type and the default Xbox360 report layout used as parameter defaults.
package usbh_report_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [7:0] nes_btn_t;

  localparam int XB360_REPORT_BITS = 160;
  localparam int XB360_AXIS_BITS   = 16;
  localparam int XB360_X_LSB       = 48;
  localparam int XB360_Y_LSB       = 64;
  localparam int XB360_BTN_A       = 28;
  localparam int XB360_BTN_B       = 29;
  localparam int XB360_BTN_START   = 20;
  localparam int XB360_BTN_SELECT  = 21;
  localparam int XB360_TURBO_A     = 25;
  localparam int XB360_TURBO_B     = 47;

endpackage

// File: rtl/usbh_axis_hyst.sv
// One signed analog axis to a pair of direction bits with on/off hysteresis.
// Thresholds are compared one bit wider so the most negative axis value is exact.
module usbh_axis_hyst #(
  parameter int c_axis_bits = 16,
  parameter int c_axis_on   = 16384,
  parameter int c_axis_off  = 8192
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clr,
  input  logic                          i_valid,
  input  logic signed [c_axis_bits-1:0] i_axis,
  output logic                          o_pos,
  output logic                          o_neg
);

  localparam int c_w = c_axis_bits + 1;

  localparam logic signed [c_w-1:0] c_on_pos  = c_w'(c_axis_on);
  localparam logic signed [c_w-1:0] c_on_neg  = c_w'(-c_axis_on);
  localparam logic signed [c_w-1:0] c_off_pos = c_w'(c_axis_off);
  localparam logic signed [c_w-1:0] c_off_neg = c_w'(-c_axis_off);

  logic signed [c_w-1:0] w_axis;
  assign w_axis = {i_axis[c_axis_bits-1], i_axis};

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pos <= 1'b0;
      o_neg <= 1'b0;
    end else if (i_valid) begin
      // Asserted: hold until below the off threshold. Idle: wait for the on threshold.
      o_pos <= o_pos ? (w_axis >= c_off_pos) : (w_axis >= c_on_pos);
      o_neg <= o_neg ? (w_axis <= c_off_neg) : (w_axis <= c_on_neg);
    end else if (i_clr) begin
      o_pos <= 1'b0;
      o_neg <= 1'b0;
    end
  end

endmodule

// File: rtl/usbh_report_decoder_gamepad.sv
// HID report to NES button decoder with axis hysteresis, exact-rate autofire and
// a report-loss watchdog enabled by the USBH_REPORT_TIMEOUT_EN macro.
module usbh_report_decoder_gamepad
  import usbh_report_pkg::*;
#(
  parameter int c_clk_hz      = 48000000,
  parameter int c_autofire_hz = 10,
  parameter int c_report_bits = XB360_REPORT_BITS,
  parameter int c_axis_bits   = XB360_AXIS_BITS,
  parameter int c_x_lsb       = XB360_X_LSB,
  parameter int c_y_lsb       = XB360_Y_LSB,
  parameter int c_axis_on     = 16384,
  parameter int c_axis_off    = 8192,
  parameter int c_btn_a       = XB360_BTN_A,
  parameter int c_btn_b       = XB360_BTN_B,
  parameter int c_btn_start   = XB360_BTN_START,
  parameter int c_btn_select  = XB360_BTN_SELECT,
  parameter int c_turbo_a     = XB360_TURBO_A,
  parameter int c_turbo_b     = XB360_TURBO_B,
  parameter int c_timeout_ms  = 100
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [c_report_bits-1:0] i_report,
  input  logic                     i_report_valid,
  output nes_btn_t                 o_btn,
  output logic                     o_active
);

  if (c_axis_off >= c_axis_on) begin : g_bad_axis_thresholds
    $error("c_axis_off must be less than c_axis_on");
  end
  if (c_timeout_ms < 1) begin : g_bad_timeout
    $error("c_timeout_ms must be at least 1");
  end

  localparam int c_af_tc = c_clk_hz / (2 * c_autofire_hz) - 1;
  localparam int c_af_w  = (c_af_tc > 0) ? $clog2(c_af_tc + 1) : 1;
  localparam logic [c_af_w-1:0] c_af_tc_v = c_af_w'(c_af_tc);

  logic r_a, r_b, r_select, r_start, r_turbo_a, r_turbo_b, r_alive;
  logic r_phase;
  logic [c_af_w-1:0] r_af_cnt;
  logic w_up, w_down, w_left, w_right;
  logic w_wd_clr;
  logic w_turbo_rise;
  nes_btn_t w_btn;

  logic w_unused;
  assign w_unused = ^i_report;

`ifdef USBH_REPORT_TIMEOUT_EN
  localparam longint c_wd_sat = (longint'(c_timeout_ms) * longint'(c_clk_hz)) / 1000;
  localparam int c_wd_w = (c_wd_sat > 1) ? $clog2(c_wd_sat + 1) : 1;
  localparam logic [c_wd_w-1:0] c_wd_sat_v = c_wd_w'(c_wd_sat);

  logic [c_wd_w-1:0] r_wd_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_report_valid) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != c_wd_sat_v) begin
      r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
    end
  end

  assign w_wd_clr = (r_wd_cnt == c_wd_sat_v);
`else
  assign w_wd_clr = 1'b0;
`endif

  // A valid report outranks a watchdog clear landing in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_select  <= 1'b0;
      r_start   <= 1'b0;
      r_turbo_a <= 1'b0;
      r_turbo_b <= 1'b0;
      r_alive   <= 1'b0;
    end else if (i_report_valid) begin
      r_a       <= i_report[c_btn_a];
      r_b       <= i_report[c_btn_b];
      r_select  <= i_report[c_btn_select];
      r_start   <= i_report[c_btn_start];
      r_turbo_a <= i_report[c_turbo_a];
      r_turbo_b <= i_report[c_turbo_b];
      r_alive   <= 1'b1;
    end else if (w_wd_clr) begin
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_select  <= 1'b0;
      r_start   <= 1'b0;
      r_turbo_a <= 1'b0;
      r_turbo_b <= 1'b0;
      r_alive   <= 1'b0;
    end
  end

  usbh_axis_hyst #(
    .c_axis_bits (c_axis_bits),
    .c_axis_on   (c_axis_on),
    .c_axis_off  (c_axis_off)
  ) u_x_hyst (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_wd_clr),
    .i_valid (i_report_valid),
    .i_axis  (i_report[c_x_lsb +: c_axis_bits]),
    .o_pos   (w_right),
    .o_neg   (w_left)
  );

  usbh_axis_hyst #(
    .c_axis_bits (c_axis_bits),
    .c_axis_on   (c_axis_on),
    .c_axis_off  (c_axis_off)
  ) u_y_hyst (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_wd_clr),
    .i_valid (i_report_valid),
    .i_axis  (i_report[c_y_lsb +: c_axis_bits]),
    .o_pos   (w_up),
    .o_neg   (w_down)
  );

  // A fresh turbo press restarts the divider so the first shot is immediate.
  assign w_turbo_rise = i_report_valid &
                        ((i_report[c_turbo_a] & ~r_turbo_a) |
                         (i_report[c_turbo_b] & ~r_turbo_b));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_af_cnt <= '0;
      r_phase  <= 1'b0;
    end else if (w_turbo_rise) begin
      r_af_cnt <= '0;
      r_phase  <= 1'b1;
    end else if (r_af_cnt == c_af_tc_v) begin
      r_af_cnt <= '0;
      r_phase  <= ~r_phase;
    end else begin
      r_af_cnt <= r_af_cnt + c_af_w'(1);
    end
  end

  // NOTE: default first so no latch is inferred.
  always_comb begin
    w_btn             = '0;
    w_btn[BTN_A]      = r_a | (r_turbo_a & r_phase);
    w_btn[BTN_B]      = r_b | (r_turbo_b & r_phase);
    w_btn[BTN_SELECT] = r_select;
    w_btn[BTN_START]  = r_start;
    w_btn[BTN_UP]     = w_up;
    w_btn[BTN_DOWN]   = w_down;
    w_btn[BTN_LEFT]   = w_left;
    w_btn[BTN_RIGHT]  = w_right;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_btn    <= '0;
      o_active <= 1'b0;
    end else begin
      o_btn    <= w_btn;
      o_active <= r_alive;
    end
  end

endmodule

// File: tb/tb_usbh_report_decoder_gamepad.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor
// pops and compares them against o_btn/o_active.
module tb_usbh_report_decoder_gamepad;

  logic         clk = 1'b0;
  logic         i_rst;
  logic [159:0] i_report;
  logic         i_report_valid;
  logic [7:0]   o_btn;
  logic         o_active;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         cyc;
    logic [7:0] btn;
    logic       active;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  usbh_report_decoder_gamepad #(
    .c_clk_hz      (1000),
    .c_autofire_hz (10),
    .c_timeout_ms  (10)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_report       (i_report),
    .i_report_valid (i_report_valid),
    .o_btn          (o_btn),
    .o_active       (o_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: state after edge k is observed on the following negedge.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_checks++;
      if (e.cyc != cyc)
        $display("FAIL %s: expectation for cyc %0d was missed (now cyc %0d)", e.name, e.cyc, cyc);
      else if (o_btn !== e.btn || o_active !== e.active)
        $display("FAIL %s cyc=%0d: got btn=%02h active=%0b, expected btn=%02h active=%0b",
                 e.name, cyc, o_btn, o_active, e.btn, e.active);
      else
        n_pass++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic push(input int k, input logic [7:0] b, input logic a, input string nm);
    exp_t e;
    int i;
    e.cyc = k; e.btn = b; e.active = a; e.name = nm;
    i = sb_q.size();
    while (i > 0 && sb_q[i-1].cyc > k) i--;
    sb_q.insert(i, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [159:0] rep);
    i_report       = rep;
    i_report_valid = 1'b1;
    tick();
    i_report_valid = 1'b0;
  endtask

  task automatic refresh(input logic [159:0] rep, input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 5 == 0) send(rep);
      else tick();
    end
  endtask

  function automatic logic [159:0] mk(input logic a, input logic b, input logic sel,
                                      input logic start, input logic ta, input logic tb,
                                      input int x, input int y);
    logic [159:0] r;
    r = '0;
    r[28] = a;
    r[29] = b;
    r[21] = sel;
    r[20] = start;
    r[25] = ta;
    r[47] = tb;
    r[63:48] = x[15:0];
    r[79:64] = y[15:0];
    return r;
  endfunction

  int hx [16] = '{20000, 10000, 5000, 10000, -32768, -10000, -5000, 32767,
                  -32768, 0, 0, 0, 0, 0, 0, 20000};
  int hy [16] = '{0, 0, 0, 0, 0, 0, 0, 0,
                  0, 16384, 8192, 8191, -16384, -16383, -8191, -20000};
  logic [7:0] he [16] = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h80,
                          8'h40, 8'h10, 8'h10, 8'h00, 8'h20, 8'h20, 8'h00, 8'hA0};

  initial begin
    logic [159:0] rep_a, rep_b, rep_none, rep_ta, rep_tb;
    int n, m, p, q, w, r;

    rep_a    = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    rep_b    = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    rep_none = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    rep_ta   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    rep_tb   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);

    i_rst = 1'b1;
    i_report_valid = 1'b0;
    i_report = '0;
    push(1, 8'h00, 1'b0, "reset_init");
    push(2, 8'h00, 1'b0, "reset_init");
    repeat (3) tick();
    i_rst = 1'b0;

    // Plain buttons and two-edge latency.
    n = cyc;
    push(n + 1, 8'h00, 1'b0, "latency_pre");
    push(n + 2, 8'h09, 1'b1, "btn_a_start");
    send(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0));
    tick();

    // Back-to-back strobes.
    n = cyc;
    push(n + 2, 8'h02, 1'b1, "b2b_first");
    push(n + 3, 8'h04, 1'b1, "b2b_second");
    send(rep_b);
    send(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
    tick();

    // Axis hysteresis table.
    for (int i = 0; i < 16; i++) begin
      n = cyc;
      push(n + 2, he[i], 1'b1, $sformatf("hyst_%0d", i));
      send(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hx[i], hy[i]));
      tick();
      tick();
    end

    // Autofire A: high from T+2, toggling every 50 cycles.
    n = cyc;
    for (int k = n + 2; k <= n + 151; k++)
      push(k, (((k - n - 2) / 50) % 2 == 0) ? 8'h01 : 8'h00, 1'b1, "autofire_a");
    refresh(rep_ta, 160);
    m = cyc;
    push(m + 2, 8'h00, 1'b1, "turbo_release");
    refresh(rep_none, 10);
    // Phase is low here; a new press must force it high.
    p = cyc;
    for (int k = p + 2; k <= p + 52; k++)
      push(k, (k <= p + 51) ? 8'h01 : 8'h00, 1'b1, "autofire_restart");
    refresh(rep_ta, 60);
    q = cyc;
    push(q + 2, 8'h02, 1'b1, "turbo_b_press");
    refresh(rep_tb, 5);
    refresh(rep_none, 5);

`ifdef USBH_REPORT_TIMEOUT_EN
    // Timeout: A held, then silence.
    w = cyc;
    push(w + 2,  8'h01, 1'b1, "wd_hold");
    push(w + 12, 8'h01, 1'b1, "wd_pre_timeout");
    push(w + 13, 8'h00, 1'b0, "wd_timeout");
    send(rep_a);
    repeat (12) tick();
    r = cyc;
    push(r + 1, 8'h00, 1'b0, "recover_pre");
    push(r + 2, 8'h01, 1'b1, "recover");
    send(rep_a);
    // Valid lands exactly in the saturation cycle.
    repeat (10) tick();
    push(r + 12, 8'h01, 1'b1, "collide_pre");
    push(r + 13, 8'h02, 1'b1, "collide_decode");
    push(r + 14, 8'h02, 1'b1, "collide_hold");
    send(rep_b);
    repeat (3) tick();
`else
    w = cyc;
    push(w + 2,    8'h01, 1'b1, "hold_start");
    push(w + 500,  8'h01, 1'b1, "hold_mid");
    push(w + 1001, 8'h01, 1'b1, "hold_end");
    send(rep_a);
    repeat (1001) tick();
`endif

    // Reset while a report is being delivered.
    r = cyc;
    for (int k = r + 1; k <= r + 5; k++) push(k, 8'h00, 1'b0, "reset_mid");
    i_rst = 1'b1;
    i_report = rep_a;
    i_report_valid = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    i_report_valid = 1'b0;
    repeat (4) tick();

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      $display("FAIL %s: expectation for cyc %0d never evaluated", e.name, e.cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
